// File: rtl/gsim_param.sv
// gsim_param: streaming Gauss-Seidel solver for a symmetric 7-band system.
// Define GSIM_EARLY_STOP_EN to stop as soon as a sweep changes no x by more than TOL.
module gsim_param #(
  parameter int N    = 16,
  parameter int B_W  = 16,
  parameter int FRAC = 16,
  parameter int X_W  = 32,
  parameter int ITER = 100,
  parameter int TOL  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [B_W-1:0] b_in,
  output logic           in_ready,
  output logic           busy,
  output logic           out_valid,
  output logic [X_W-1:0] x_out,
  output logic [15:0]    sweep_cnt
);

  localparam int IW  = $clog2(N + 1);
  localparam int IXW = $clog2(N);
  localparam int PIW = $clog2(N + 6);
  localparam int SW  = X_W + 6;
  localparam int PW  = SW + 17;
  localparam int XD  = X_W + 1;

  localparam logic signed [SW-1:0] C13   = SW'(13);
  localparam logic signed [SW-1:0] C6    = SW'(6);
  localparam logic signed [PW-1:0] KMUL  = PW'(52429);
  localparam logic signed [PW-1:0] KRND  = PW'(524288);
  localparam logic signed [PW-1:0] XMAX  = PW'((64'sd1 <<< (X_W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] XMIN  = ~XMAX;
  localparam logic [15:0]          ITER1 = 16'(ITER - 1);

  typedef enum logic [1:0] {StLoad, StSolve, StOut} state_e;

  state_e                r_state, w_state_d;
  logic [IW-1:0]         r_idx;
  logic [15:0]           r_sweep;
  logic signed [X_W-1:0] r_x [N];
  logic signed [B_W-1:0] r_b [N];
  logic                  r_out_valid;
  logic [X_W-1:0]        r_x_out;

  logic [PIW-1:0]        w_pi;
  logic signed [SW-1:0]  w_pad [N+6];
  logic signed [B_W-1:0] w_bi;
  logic signed [SW-1:0]  w_s;
  logic signed [PW-1:0]  w_p, w_q;
  logic signed [X_W-1:0] w_xnew;
  logic                  w_stop, w_last_upd, w_done;

  // Three zero guard entries on each side absorb out-of-range neighbours.
  always_comb begin
    for (int k = 0; k < N + 6; k++) w_pad[k] = '0;
    for (int k = 0; k < N; k++) w_pad[k+3] = SW'(r_x[k]);
  end

  always_comb begin
    w_pi = PIW'(r_idx);
    w_bi = r_b[IXW'(r_idx)];
    w_s  = (SW'(w_bi) <<< FRAC)
         + C13 * (w_pad[w_pi + PIW'(2)] + w_pad[w_pi + PIW'(4)])
         - C6  * (w_pad[w_pi + PIW'(1)] + w_pad[w_pi + PIW'(5)])
         + (w_pad[w_pi] + w_pad[w_pi + PIW'(6)]);
    w_p  = PW'(w_s) * KMUL + KRND;
    w_q  = w_p >>> 20;
    if (w_q > XMAX)      w_xnew = XMAX[X_W-1:0];
    else if (w_q < XMIN) w_xnew = XMIN[X_W-1:0];
    else                 w_xnew = w_q[X_W-1:0];
  end

`ifdef GSIM_EARLY_STOP_EN
  logic [XD-1:0]        r_dmax, w_dcur, w_dmax;
  logic signed [XD-1:0] w_diff;

  always_comb begin
    w_diff = XD'(w_xnew) - XD'(r_x[IXW'(r_idx)]);
    w_dcur = w_diff[XD-1] ? -w_diff : w_diff;
    w_dmax = (w_dcur > r_dmax) ? w_dcur : r_dmax;
    w_stop = (w_dmax <= XD'(TOL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         r_dmax <= '0;
    else if (r_state != StSolve || r_idx == IW'(N-1))  r_dmax <= '0;
    else                                               r_dmax <= w_dmax;
  end
`else
  logic w_unused_tol;
  assign w_unused_tol = ^TOL;
  assign w_stop       = 1'b0;
`endif

  assign w_last_upd = (r_state == StSolve) && (r_idx == IW'(N-1));
  assign w_done     = w_last_upd && ((r_sweep == ITER1) || w_stop);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLoad:  if (in_en && r_idx == IW'(N-1)) w_state_d = StSolve;
      StSolve: if (w_done) w_state_d = StOut;
      StOut:   if (r_idx == IW'(N)) w_state_d = StLoad;
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StLoad;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_sweep     <= '0;
      r_out_valid <= 1'b0;
      r_x_out     <= '0;
      for (int k = 0; k < N; k++) begin
        r_x[k] <= '0;
        r_b[k] <= '0;
      end
    end else begin
      unique case (r_state)
        StLoad: begin
          if (in_en) begin
            r_b[IXW'(r_idx)] <= b_in;
            if (r_idx == IW'(N-1)) begin
              r_idx   <= '0;
              r_sweep <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        StSolve: begin
          r_x[IXW'(r_idx)] <= w_xnew;
          if (w_last_upd) begin
            r_sweep <= r_sweep + 16'd1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
          // x[0] is already final when the last unknown of the last sweep is written.
          if (w_done) begin
            r_out_valid <= 1'b1;
            r_x_out     <= r_x[0];
            r_idx       <= IW'(1);
          end
        end
        StOut: begin
          if (r_idx == IW'(N)) begin
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            r_idx       <= '0;
            for (int k = 0; k < N; k++) r_x[k] <= '0;
          end else begin
            r_x_out <= r_x[IXW'(r_idx)];
            r_idx   <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StLoad);
  assign busy      = (r_state != StLoad);
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign sweep_cnt = r_sweep;

endmodule

// File: tb/tb_gsim_param.sv
// Randomised self-checking bench for gsim_param against a plain-integer Gauss-Seidel model.
module tb_gsim_param;

  localparam int N    = 16;
  localparam int B_W  = 16;
  localparam int FRAC = 16;
  localparam int X_W  = 32;
  localparam int ITER = 100;
  localparam int TOL  = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_en;
  logic [B_W-1:0] b_in;
  logic           in_ready, busy, out_valid;
  logic [X_W-1:0] x_out;
  logic [15:0]    sweep_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  longint mb [N];
  longint mx [N];
  int     msweeps;

  gsim_param #(
    .N(N), .B_W(B_W), .FRAC(FRAC), .X_W(X_W), .ITER(ITER), .TOL(TOL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .x_out     (x_out),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint xa(input int k);
    return (k >= 0 && k < N) ? mx[k] : 64'sd0;
  endfunction

  // Solve M x = b directly from the sweep definition with 64-bit integers.
  task automatic run_model();
    longint s, q, d, lim;
    lim = (64'sd1 <<< (X_W - 1));
    for (int k = 0; k < N; k++) mx[k] = 0;
    msweeps = 0;
    forever begin
      d = 0;
      for (int i = 0; i < N; i++) begin
        s = mb[i] * (64'sd1 <<< FRAC)
          + 13 * (xa(i-1) + xa(i+1)) - 6 * (xa(i-2) + xa(i+2)) + (xa(i-3) + xa(i+3));
        q = (s * 52429 + 524288) >>> 20;
        if (q > lim - 1) q = lim - 1;
        if (q < -lim)    q = -lim;
        if ((q - mx[i] > d) || (mx[i] - q > d)) d = (q > mx[i]) ? q - mx[i] : mx[i] - q;
        mx[i] = q;
      end
      msweeps++;
      if (msweeps == ITER) break;
`ifdef GSIM_EARLY_STOP_EN
      if (d <= TOL) break;
`endif
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  longint'(in_ready),  1);
    chk({tag, "_busy"},      longint'(busy),      0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_x_out"},     longint'(x_out),     0);
    chk({tag, "_sweep_cnt"}, longint'(sweep_cnt), 0);
  endtask

  task automatic load_frame();
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_en = 1'b0;
        b_in  = B_W'($urandom);
        @(negedge clk);
      end
      in_en = 1'b1;
      b_in  = mb[k][B_W-1:0];
      @(negedge clk);
    end
    in_en = 1'b0;
  endtask

  // Loads mb, checks latency, handshake, every x value and the idle state afterwards.
  task automatic run_frame(input string tag, input bit noise, input int tol1);
    int n;
    bit rdy_ok, busy_ok;
    longint xv;
    run_model();
    load_frame();
    n = 1;
    rdy_ok = 1'b1;
    busy_ok = 1'b1;
    while (!out_valid && n <= 3 * N * ITER) begin
      if (in_ready) rdy_ok = 1'b0;
      if (!busy)    busy_ok = 1'b0;
      in_en = noise & ~in_ready;
      b_in  = B_W'($urandom);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"},   longint'(n),       longint'(1 + N * msweeps));
    chk({tag, "_rdy_low"},   longint'(rdy_ok),  1);
    chk({tag, "_busy_high"}, longint'(busy_ok), 1);
    for (int k = 0; k < N; k++) begin
      xv = longint'($signed(x_out));
      chk($sformatf("%s_x%0d", tag, k), xv, mx[k]);
      chk($sformatf("%s_valid%0d", tag, k), longint'(out_valid), 1);
      if (in_ready) rdy_ok = 1'b0;
      if (tol1 > 0)
        chk($sformatf("%s_near1_%0d", tag, k),
            longint'((xv - 65536 <= tol1) && (65536 - xv <= tol1)), 1);
      if (k == 0) chk({tag, "_sweep_cnt"}, longint'(sweep_cnt), longint'(msweeps));
      in_en = noise & ~in_ready;
      b_in  = B_W'($urandom);
      @(negedge clk);
    end
    in_en = 1'b0;
    chk({tag, "_rdy_low_out"}, longint'(rdy_ok),    1);
    chk({tag, "_valid_end"},   longint'(out_valid), 0);
    chk({tag, "_x_end"},       longint'(x_out),     0);
    chk({tag, "_ready_end"},   longint'(in_ready),  1);
    chk({tag, "_busy_end"},    longint'(busy),      0);
  endtask

  task automatic set_ones_rhs();
    for (int i = 0; i < N; i++) begin
      mb[i] = 20;
      for (int j = 0; j < N; j++) begin
        if (j == i - 1 || j == i + 1) mb[i] -= 13;
        if (j == i - 2 || j == i + 2) mb[i] += 6;
        if (j == i - 3 || j == i + 3) mb[i] -= 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int i = 0; i < N; i++) mb[i] = 0;
    run_frame("zero", 1'b0, 0);

    set_ones_rhs();
    run_frame("ones", 1'b0, 64);

    for (int i = 0; i < N; i++) mb[i] = longint'($urandom_range(0, 2000)) - 1000;
    run_frame("rand_noise", 1'b1, 0);
    run_frame("rand_clean", 1'b0, 0);

    for (int i = 0; i < N; i++) mb[i] = longint'($signed(B_W'($urandom)));
    run_frame("rand_full", 1'b1, 0);

    // Frame A is aborted mid-solve; frame B must match a standalone run.
    for (int i = 0; i < N; i++) mb[i] = longint'($urandom_range(0, 600)) - 300;
    load_frame();
    repeat (50 * N) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort_during");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort_after");
    for (int i = 0; i < N; i++) mb[i] = longint'($urandom_range(0, 4000)) - 2000;
    run_frame("frame_b", 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gsim_param.md
# gsim_param

Parametrised Gauss-Seidel solver for the banded system M·x = b. M is N×N, symmetric, with diagonal 20 and off-diagonals −13, 6 and −1 at distances 1, 2 and 3. It accepts N signed integer b values on a streaming input and runs a configurable number of in-place Gauss-Seidel sweeps. It then streams the N fixed-point x values out. It generalises the fixed 16-unknown GSIM engine in unknown count, data width, fraction width and iteration count, and adds an input-ready handshake and a sweep counter.

## Interface
- `N`, default 16: number of unknowns; legal range 4..64.
- `B_W`, default 16: width of b, signed two's complement integer.
- `FRAC`, default 16: fraction bits of x.
- `X_W`, default 32: width of x, signed, Q(X_W−FRAC).FRAC; must satisfy X_W ≥ B_W+FRAC.
- `ITER`, default 100: maximum number of sweeps; range 1..65535.
- `TOL`, default 1: early-stop threshold in x LSBs; used only with the early-stop option.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_en` input 1: b sample valid.
- `b_in` input B_W: b sample, indices 0..N−1 in order.
- `in_ready` output 1: block accepts b.
- `busy` output 1: block is solving or outputting.
- `out_valid` output 1: x_out valid.
- `x_out` output X_W: x value, indices 0..N−1 in order.
- `sweep_cnt` output 16: number of sweeps performed; valid while out_valid is high.

## Operation
- States:
  - LOAD: in_ready=1, busy=0.
  - SOLVE: in_ready=0, busy=1.
  - OUT: in_ready=0, busy=1.
- LOAD:
  - Each cycle with in_en && in_ready stores b_in at the load index, then increments the index.
  - All x registers are held at 0.
  - Accepting index N−1 moves the block to SOLVE with sweep=0 and i=0.
- SOLVE updates one unknown per cycle, i = 0..N−1, in place.
  - Index i uses the new values already computed for lower indices (Gauss-Seidel ordering).
  - Neighbour indices outside 0..N−1 contribute 0.
  - s = (b_i << FRAC) + 13(x[i−1]+x[i+1]) − 6(x[i−2]+x[i+2]) + (x[i−3]+x[i+3]).
  - s is computed signed at X_W+6 bits, with no overflow possible.
  - x_new = (s·52429 + 2^19) >>> 20. This is a signed multiply by 1/20 rounded to nearest.
  - x_new is saturated to the X_W signed range before write-back.
  - When i=N−1, sweep increments. When sweep reaches ITER, the block moves to OUT.
- OUT:
  - out_valid=1 for exactly N consecutive cycles, with x_out = x[0], x[1], …, x[N−1].
  - sweep_cnt holds the final sweep count.
  - The block then returns to LOAD; the load index is 0 and x registers are cleared on entry to LOAD.
- in_en while in_ready=0 is ignored; b_in is don't-care.
- Reset at any time:
  - state=LOAD, indices=0, all b and x registers=0.
  - in_ready=1, busy=0, out_valid=0, x_out=0, sweep_cnt=0.
  - A partially loaded or partially solved frame is discarded.

## Timing
- Load: N accepted samples. Gaps with in_en=0 are allowed and simply stall.
- SOLVE starts on the edge after the N-th accepted sample.
- Solve takes exactly N·ITER cycles without early stop.
- The first out_valid is the cycle after the final update. The first x_out is visible 1 + N·ITER cycles after the last sample edge.
- out_valid is continuous for N cycles; there is no downstream backpressure.
- in_ready rises the cycle after the last out_valid. A new frame may start that same cycle.
- x_out and out_valid are registered. x_out is 0 whenever out_valid=0.

## Configuration
- `GSIM_EARLY_STOP_EN` defined:
  - During each sweep, track d = max |x_new − x_old|.
  - At the end of a sweep, if d ≤ TOL, go to OUT immediately, even if sweep < ITER.
  - At least 1 sweep is always performed; ITER remains the cap.
  - sweep_cnt reports the actual number of sweeps.
- `GSIM_EARLY_STOP_EN` undefined:
  - No delta logic is built.
  - The block always performs ITER sweeps and sweep_cnt = ITER.

## Test plan
- All-zero b, N=16, ITER=100:
  - every x_out = 0x00000000;
  - out_valid high 16 cycles, starting 1601 cycles after the last input edge;
  - sweep_cnt = 100 (1 with early stop).
- b = M·1, N=16: b = 12, −1, 5, 4×10, 5, −1, 12 (that is, 4 at indices 3..12).
  - Required: every x_out within ±0x40 of 0x00010000.
- The 16-sample GSIM production pattern:
  - Σ(M·x − b)² < 1e-4, computed with x interpreted as Q16.16;
  - sign and magnitude of each x agree with the golden values to 1e-2.
- in_en=1 with random b_in throughout SOLVE and OUT:
  - result is identical to a clean run;
  - in_ready is low throughout that window.
- Reset pulse at sweep 50 of frame A, then load frame B:
  - all outputs are at reset values during and after the pulse;
  - frame B's output equals a standalone run of B.
- N=8, B_W=12, ITER=20, b = M·1 (rows computed for N=8):
  - out_valid is exactly 8 cycles long, starting 161 cycles after the last input;
  - x_out ≈ 0x00010000 within ±0x400.
